// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a time,
// buffers a single returned instruction for decode, handles branch/exception
// redirects by discarding in-flight responses, and sequences fence.i icache flushes.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h8000_0000,
    parameter int unsigned FENCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] br_target,
    input  logic [31:0] jalr_target,
    input  logic [31:0] exc_target,
    input  logic        fence_i,
    input  logic [31:0] fence_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        icache_flush
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] FENCE_CNT = 8'(FENCE_CYCLES);

    state_t      state_r,         state_n_s;
    logic [31:0] pc_r,            pc_n_s;
    logic [31:0] pc_seq_s;
    logic [31:0] req_pc_r,        req_pc_n_s;
    logic        buf_valid_r,     buf_valid_n_s;
    logic [31:0] buf_inst_r,      buf_inst_n_s;
    logic [31:0] buf_pc_r,        buf_pc_n_s;
    logic        kill_pending_r,  kill_pending_n_s;
    logic        fence_pending_r, fence_pending_n_s;
    logic [7:0]  flush_cnt_r,     flush_cnt_n_s;

    logic        req_valid_s;
    logic        req_fire_s;
    logic        redirect_s;
    logic        fence_take_s;
    logic        outstanding_s;
    logic [31:0] target_s;

    // A request is offered only when idle, the buffer is free and no flush is queued;
    // reset gates it directly so nothing is offered while reset is held.
    assign req_valid_s    = (state_r == ST_FETCH) && !buf_valid_r && !fence_pending_r && !reset;
    assign req_fire_s     = req_valid_s && imem_req_ready;
    assign redirect_s     = (pc_sel != 2'd0);
    assign fence_take_s   = fence_i && !redirect_s;
    // A request is still in flight after this edge if one is just accepted, or we
    // are waiting and its response has not arrived this cycle.
    assign outstanding_s  = req_fire_s || ((state_r == ST_WAIT) && !imem_resp_valid);

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign inst_valid     = buf_valid_r;
    assign inst           = buf_inst_r;
    assign inst_pc        = buf_pc_r;
    assign icache_flush   = (state_r == ST_FLUSH);

    // Select the redirect target requested by the branch unit.
    always_comb begin
        target_s = pc_r;
        case (pc_sel)
            2'd1:    target_s = br_target;
            2'd2:    target_s = jalr_target;
            2'd3:    target_s = exc_target;
            default: target_s = pc_r;
        endcase
    end

    // Next-state and datapath update: FSM progression first, then redirect/fence overrides.
    always_comb begin
        state_n_s         = state_r;
        pc_seq_s          = pc_r;
        pc_n_s            = pc_r;
        req_pc_n_s        = req_pc_r;
        buf_valid_n_s     = buf_valid_r;
        buf_inst_n_s      = buf_inst_r;
        buf_pc_n_s        = buf_pc_r;
        kill_pending_n_s  = kill_pending_r;
        fence_pending_n_s = fence_pending_r;
        flush_cnt_n_s     = flush_cnt_r;

        // Decode takes the buffered instruction when it is not stalled.
        if (buf_valid_r && !stall) begin
            buf_valid_n_s = 1'b0;
        end else begin
            buf_valid_n_s = buf_valid_r;
        end

        case (state_r)
            ST_FETCH: begin
                if (fence_pending_r) begin
                    state_n_s         = ST_FLUSH;
                    flush_cnt_n_s     = FENCE_CNT;
                    fence_pending_n_s = 1'b0;
                end else if (req_fire_s) begin
                    state_n_s  = ST_WAIT;
                    req_pc_n_s = pc_r;
                    pc_seq_s   = pc_r + 32'd4;
                end else begin
                    state_n_s = ST_FETCH;
                end
            end
            ST_WAIT: begin
                if (imem_resp_valid) begin
                    state_n_s = ST_FETCH;
                    if (kill_pending_r) begin
                        kill_pending_n_s = 1'b0;
                    end else begin
                        buf_valid_n_s = 1'b1;
                        buf_inst_n_s  = imem_resp_data;
                        buf_pc_n_s    = req_pc_r;
                    end
                end else begin
                    state_n_s = ST_WAIT;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r > 8'd1) begin
                    flush_cnt_n_s = flush_cnt_r - 8'd1;
                end else begin
                    flush_cnt_n_s = 8'd0;
                    state_n_s     = ST_FETCH;
                end
            end
            default: begin
                state_n_s = ST_FETCH;
            end
        endcase

        // Redirect beats fence.i; during a flush only the PC (and flush length) change.
        if (redirect_s) begin
            pc_n_s = target_s;
            if (state_r != ST_FLUSH) begin
                buf_valid_n_s    = 1'b0;
                kill_pending_n_s = kill_pending_n_s | outstanding_s;
            end else begin
                buf_valid_n_s = buf_valid_n_s;
            end
        end else if (fence_take_s) begin
            pc_n_s = fence_pc;
            if ((state_r == ST_FLUSH) || ((state_r == ST_FETCH) && fence_pending_r)) begin
                // A flush is already running or starting now; restart its length.
                state_n_s     = ST_FLUSH;
                flush_cnt_n_s = FENCE_CNT;
            end else begin
                buf_valid_n_s     = 1'b0;
                fence_pending_n_s = 1'b1;
                kill_pending_n_s  = kill_pending_n_s | outstanding_s;
            end
        end else begin
            pc_n_s = pc_seq_s;
        end
    end

    // State registers with asynchronous reset; an outstanding request is abandoned on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r         <= ST_FETCH;
            pc_r            <= RESET_PC;
            req_pc_r        <= RESET_PC;
            buf_valid_r     <= 1'b0;
            buf_inst_r      <= 32'd0;
            buf_pc_r        <= 32'd0;
            kill_pending_r  <= 1'b0;
            fence_pending_r <= 1'b0;
            flush_cnt_r     <= 8'd0;
        end else begin
            state_r         <= state_n_s;
            pc_r            <= pc_n_s;
            req_pc_r        <= req_pc_n_s;
            buf_valid_r     <= buf_valid_n_s;
            buf_inst_r      <= buf_inst_n_s;
            buf_pc_r        <= buf_pc_n_s;
            kill_pending_r  <= kill_pending_n_s;
            fence_pending_r <= fence_pending_n_s;
            flush_cnt_r     <= flush_cnt_n_s;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: behavioural instruction memory with
// configurable latency, scoreboard of expected instructions, directed scenarios.
module tb_fetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  pc_sel;
    logic [31:0] br_target, jalr_target, exc_target;
    logic        fence_i;
    logic [31:0] fence_pc;
    logic        stall;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        icache_flush;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // scoreboard: exp_* filled on request accept, want_* matched to got_* on consume
    logic [31:0] exp_pc_q[$], exp_inst_q[$];
    logic [31:0] want_pc_q[$], want_inst_q[$];
    logic [31:0] got_pc_q[$], got_inst_q[$];

    // memory model
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;

    fetch_ctrl #(.RESET_PC(RST_PC), .FENCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .pc_sel(pc_sel),
        .br_target(br_target), .jalr_target(jalr_target), .exc_target(exc_target),
        .fence_i(fence_i), .fence_pc(fence_pc), .stall(stall),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready), .imem_resp_valid(imem_resp_valid),
        .imem_resp_data(imem_resp_data), .inst_valid(inst_valid), .inst(inst),
        .inst_pc(inst_pc), .icache_flush(icache_flush)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) | 32'h0000_0013;
    endfunction

    // One clock cycle: record handshakes, advance DUT, update memory model at negedge.
    task automatic cyc();
        bit          acc;
        logic [31:0] acc_addr;
        #1;
        acc      = imem_req_valid && imem_req_ready;
        acc_addr = imem_req_addr;
        if (inst_valid && !stall) begin
            got_pc_q.push_back(inst_pc);
            got_inst_q.push_back(inst);
            if (exp_pc_q.size() > 0) begin
                want_pc_q.push_back(exp_pc_q.pop_front());
                want_inst_q.push_back(exp_inst_q.pop_front());
            end else begin
                want_pc_q.push_back(32'hxxxx_xxxx);
                want_inst_q.push_back(32'hxxxx_xxxx);
            end
        end
        if (acc) begin
            exp_pc_q.push_back(acc_addr);
            exp_inst_q.push_back(mem_word(acc_addr));
        end
        if (pc_sel != 2'd0 || fence_i || reset) begin
            exp_pc_q.delete();
            exp_inst_q.delete();
        end
        @(posedge clk);
        @(negedge clk);
        if (imem_resp_valid) begin
            imem_resp_valid = 1'b0;
            mem_busy        = 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt > 1) mem_cnt = mem_cnt - 1;
        end
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = mem_lat;
        end
        if (mem_busy && mem_cnt <= 1 && !imem_resp_valid) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = mem_word(mem_addr);
        end
        #1;
    endtask

    // Advance until a request is offered (bounded), tallying inst_valid and flush cycles.
    task automatic wait_req(input int max, output bit ok, output int iv, output int fl);
        ok = 1'b0; iv = 0; fl = 0;
        for (int i = 0; i < max; i++) begin
            if (imem_req_valid) begin
                ok = 1'b1;
                break;
            end
            iv += int'(inst_valid);
            fl += int'(icache_flush);
            cyc();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pc_sel = 2'd0; br_target = 32'd0; jalr_target = 32'd0; exc_target = 32'd0;
        fence_i = 1'b0; fence_pc = 32'd0; stall = 1'b0; imem_req_ready = 1'b1;
        imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
        @(negedge clk); #1;
        repeat (3) cyc();
        total_cnt++; if (imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); else pass_cnt++;
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL rst_inst_valid: got %b expected 0", inst_valid); else pass_cnt++;
        total_cnt++; if (icache_flush !== 1'b0) $display("FAIL rst_flush: got %b expected 0", icache_flush); else pass_cnt++;
        total_cnt++; if (imem_req_addr !== RST_PC) $display("FAIL rst_addr: got %h expected %h", imem_req_addr, RST_PC); else pass_cnt++;
        reset = 1'b0; #1;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
            $display("FAIL rst_release_req: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RST_PC); else pass_cnt++;
    endtask

    task automatic test_basic();
        mem_lat = 1;
        cyc();  // request 8000_0000 accepted
        total_cnt++; if (inst_valid !== 1'b0) $display("FAIL basic_early_valid: got %b expected 0", inst_valid); else pass_cnt++;
        cyc();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== RST_PC || inst !== 32'h0000_0013)
            $display("FAIL basic_inst: got %b/%h/%h expected 1/%h/00000013", inst_valid, inst_pc, inst, RST_PC); else pass_cnt++;
        cyc();
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004)
            $display("FAIL basic_next_req: got %b/%h expected 1/80000004", imem_req_valid, imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_latency();
        bit ok; int iv, fl, n;
        logic [31:0] a;
        mem_lat = 3;
        wait_req(20, ok, iv, fl);
        a = imem_req_addr;
        cyc();
        n = 1;
        while (!inst_valid && n < 20) begin
            cyc();
            n++;
        end
        total_cnt++; if (n !== 4) $display("FAIL latency_cycles: got %0d expected 4", n); else pass_cnt++;
        total_cnt++; if (inst_pc !== a || inst !== mem_word(a))
            $display("FAIL latency_inst: got %h/%h expected %h/%h", inst_pc, inst, a, mem_word(a)); else pass_cnt++;
        cyc();
    endtask

    task automatic test_stall();
        bit ok; int iv, fl, bad;
        logic [31:0] a;
        mem_lat = 1;
        wait_req(20, ok, iv, fl);
        a = imem_req_addr;
        stall = 1'b1;
        cyc(); cyc();
        total_cnt++; if (inst_valid !== 1'b1) $display("FAIL stall_fill: got %b expected 1", inst_valid); else pass_cnt++;
        bad = 0;
        repeat (5) begin
            if (inst_valid !== 1'b1 || inst_pc !== a || imem_req_valid !== 1'b0) bad++;
            cyc();
        end
        total_cnt++; if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); else pass_cnt++;
        stall = 1'b0;
        cyc();
        total_cnt++; if (imem_req_valid !== 1'b1 || inst_valid !== 1'b0 || imem_req_addr !== a + 32'd4)
            $display("FAIL stall_release: got %b/%b/%h expected 1/0/%h", imem_req_valid, inst_valid, imem_req_addr, a + 32'd4); else pass_cnt++;
    endtask

    task automatic test_redirect();
        bit ok; int iv, fl;
        mem_lat = 3;
        wait_req(20, ok, iv, fl);
        cyc();
        pc_sel = 2'd1; br_target = 32'h8000_0100;
        cyc();
        pc_sel = 2'd0;
        wait_req(20, ok, iv, fl);
        total_cnt++; if (ok !== 1'b1) $display("FAIL redirect_timeout: got %b expected 1", ok); else pass_cnt++;
        total_cnt++; if (iv !== 0) $display("FAIL redirect_discard: got %0d expected 0", iv); else pass_cnt++;
        total_cnt++; if (imem_req_addr !== 32'h8000_0100) $display("FAIL redirect_addr: got %h expected 80000100", imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_fence();
        bit ok; int iv, fl;
        mem_lat = 3;
        wait_req(20, ok, iv, fl);
        cyc();
        fence_i = 1'b1; fence_pc = 32'h8000_0040;
        cyc();
        fence_i = 1'b0;
        wait_req(30, ok, iv, fl);
        total_cnt++; if (fl !== 4) $display("FAIL fence_flush_len: got %0d expected 4", fl); else pass_cnt++;
        total_cnt++; if (iv !== 0) $display("FAIL fence_discard: got %0d expected 0", iv); else pass_cnt++;
        total_cnt++; if (ok !== 1'b1 || imem_req_addr !== 32'h8000_0040)
            $display("FAIL fence_addr: got %b/%h expected 1/80000040", ok, imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_fence_redirect();
        bit ok; int iv, fl;
        mem_lat = 1;
        wait_req(20, ok, iv, fl);
        fence_i = 1'b1; fence_pc = 32'h8000_0080; pc_sel = 2'd3; exc_target = 32'h0000_0100;
        cyc();
        fence_i = 1'b0; pc_sel = 2'd0;
        wait_req(30, ok, iv, fl);
        total_cnt++; if (fl !== 0) $display("FAIL fence_exc_flush: got %0d expected 0", fl); else pass_cnt++;
        total_cnt++; if (ok !== 1'b1 || iv !== 0 || imem_req_addr !== 32'h0000_0100)
            $display("FAIL fence_exc_addr: got %b/%0d/%h expected 1/0/00000100", ok, iv, imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_flush_redirect();
        bit ok, done; int iv, fl;
        mem_lat = 1;
        wait_req(20, ok, iv, fl);
        fence_i = 1'b1; fence_pc = 32'h8000_0200;
        cyc();
        fence_i = 1'b0;
        fl = 0; done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (imem_req_valid) break;
            fl += int'(icache_flush);
            if (icache_flush && !done) begin
                pc_sel = 2'd1; br_target = 32'h8000_0300; done = 1'b1;
            end
            cyc();
            pc_sel = 2'd0;
        end
        total_cnt++; if (fl !== 4) $display("FAIL flush_redir_len: got %0d expected 4", fl); else pass_cnt++;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300)
            $display("FAIL flush_redir_addr: got %b/%h expected 1/80000300", imem_req_valid, imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_wrap();
        bit ok; int iv, fl;
        mem_lat = 1;
        wait_req(20, ok, iv, fl);
        pc_sel = 2'd2; jalr_target = 32'hFFFF_FFFC;
        cyc();  // accepted in the redirect cycle, so its response must be dropped
        pc_sel = 2'd0;
        wait_req(20, ok, iv, fl);
        total_cnt++; if (ok !== 1'b1 || iv !== 0 || imem_req_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_jalr_addr: got %b/%0d/%h expected 1/0/fffffffc", ok, iv, imem_req_addr); else pass_cnt++;
        cyc(); cyc();
        total_cnt++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC || inst !== 32'hFFFF_FC13)
            $display("FAIL wrap_inst: got %b/%h/%h expected 1/fffffffc/fffffc13", inst_valid, inst_pc, inst); else pass_cnt++;
        cyc();
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000)
            $display("FAIL wrap_next_addr: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok; int iv, fl;
        mem_lat = 5;
        wait_req(20, ok, iv, fl);
        cyc(); cyc();
        #2;
        reset = 1'b1;
        #1;
        total_cnt++; if (imem_req_addr !== RST_PC || imem_req_valid !== 1'b0 || inst_valid !== 1'b0 || icache_flush !== 1'b0)
            $display("FAIL reset_async: got %h/%b/%b/%b expected %h/0/0/0", imem_req_addr, imem_req_valid, inst_valid, icache_flush, RST_PC); else pass_cnt++;
        cyc(); cyc();
        mem_busy = 1'b0; imem_resp_valid = 1'b0;
        reset = 1'b0;
        #1;
        total_cnt++; if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC)
            $display("FAIL reset_restart: got %b/%h expected 1/%h", imem_req_valid, imem_req_addr, RST_PC); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        got_pc_q.delete(); got_inst_q.delete(); want_pc_q.delete(); want_inst_q.delete();
        for (int i = 0; i < 80; i++) begin
            stall   = ($urandom_range(0, 3) == 0);
            mem_lat = $urandom_range(1, 3);
            cyc();
        end
        stall = 1'b0;
        repeat (10) cyc();
        total_cnt++; if (got_pc_q.size() < 10) $display("FAIL b2b_count: got %0d expected >= 10", got_pc_q.size()); else pass_cnt++;
        total_cnt++; if (got_pc_q[0] !== RST_PC) $display("FAIL b2b_first_pc: got %h expected %h", got_pc_q[0], RST_PC); else pass_cnt++;
        for (int i = 0; i < got_pc_q.size(); i++) begin
            total_cnt++;
            if (got_pc_q[i] !== want_pc_q[i] || got_inst_q[i] !== want_inst_q[i])
                $display("FAIL b2b_item%0d: got %h/%h expected %h/%h", i, got_pc_q[i], got_inst_q[i], want_pc_q[i], want_inst_q[i]);
            else pass_cnt++;
            if (i > 0) begin
                total_cnt++;
                if (got_pc_q[i] !== got_pc_q[i-1] + 32'd4)
                    $display("FAIL b2b_seq%0d: got %h expected %h", i, got_pc_q[i], got_pc_q[i-1] + 32'd4);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_latency();
        test_stall();
        test_redirect();
        test_fence();
        test_fence_redirect();
        test_flush_redirect();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, 32'h8000_0000, PC loaded on reset.
REQ-002 Parameter FENCE_CYCLES, 4, number of cycles icache_flush is held high per fence.i (legal range 1..255).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 pc_sel  input  2  next-PC select from branch unit: 0 PC_4, 1 PC_BRJMP, 2 PC_JALR, 3 PC_EXC.
REQ-006 br_target / jalr_target / exc_target  input  32 each  redirect targets for pc_sel 1/2/3.
REQ-007 fence_i  input  1  one-cycle pulse: fence.i retiring from execute.
REQ-008 fence_pc  input  32  restart address after fence.i (fence PC + 4).
REQ-009 stall  input  1  decode cannot accept an instruction this cycle.
REQ-010 imem_req_valid  output  1 / imem_req_addr  output  32 / imem_req_ready  input  1  instruction memory request handshake.
REQ-011 imem_resp_valid  input  1 / imem_resp_data  input  32  instruction memory response, one per accepted request, arbitrary latency >= 1 cycle.
REQ-012 inst_valid  output  1 / inst  output  32 / inst_pc  output  32  instruction handed to decode.
REQ-013 icache_flush  output  1  icache invalidate strobe.

Function
REQ-014 States: FETCH (no request outstanding), WAIT (one request outstanding), FLUSH (icache invalidate in progress); at most one request outstanding ever.
REQ-015 Registers: pc (next fetch address), req_pc (address of outstanding request), one-entry instruction buffer (buf_valid, buf_inst, buf_pc), kill_pending, fence_pending, 8-bit flush counter.
REQ-016 imem_req_valid = 1 only in FETCH with buf_valid=0, fence_pending=0, reset=0; imem_req_addr = pc.
REQ-017 Request accepted when imem_req_valid && imem_req_ready: req_pc <= pc, pc <= pc + 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), state -> WAIT.
REQ-018 In WAIT, imem_resp_valid with kill_pending=0: buffer <= {1, imem_resp_data, req_pc}, state -> FETCH; with kill_pending=1: response discarded, kill_pending <= 0, state -> FETCH.
REQ-019 Responses arriving in FETCH or FLUSH are ignored.
REQ-020 inst_valid = buf_valid, inst = buf_inst, inst_pc = buf_pc; buffer consumed (buf_valid <= 0) in a cycle with inst_valid=1 and stall=0.
REQ-021 Redirect when pc_sel != 0: pc <= target chosen by pc_sel, buf_valid <= 0, and kill_pending <= 1 if a request is outstanding after this edge (WAIT, or request accepted in the same cycle).
REQ-022 Redirect overrides the +4 update of REQ-017 and any buffer fill of REQ-018 in the same cycle; a response arriving in the redirect cycle is discarded.
REQ-023 fence_i with pc_sel=0: pc <= fence_pc, buf_valid <= 0, fence_pending <= 1, kill_pending set as in REQ-021.
REQ-024 fence_i with pc_sel != 0 in the same cycle: redirect wins, fence_i ignored.
REQ-025 FETCH with fence_pending=1: state -> FLUSH, counter <= FENCE_CYCLES, fence_pending <= 0; WAIT with fence_pending waits for the (discarded) response first.
REQ-026 FLUSH: icache_flush = 1, counter decrements each cycle, state -> FETCH after counter reaches 1; no requests issued.
REQ-027 Redirect during FLUSH updates pc only; flush runs to completion. fence_i during FLUSH updates pc and reloads counter to FENCE_CYCLES.
REQ-028 Latency: accepted request to inst_valid = response latency + 1 cycle; inst_valid-consume to next imem_req_valid = 1 cycle.

Reset
REQ-029 While reset is high: state FETCH, pc = RESET_PC, buf_valid = kill_pending = fence_pending = 0, counter = 0; outputs imem_req_valid = 0, inst_valid = 0, icache_flush = 0, imem_req_addr = RESET_PC.
REQ-030 Reset asserted mid-transaction abandons the outstanding request; the first response after reset release is treated per REQ-019 only if no request has been issued since.

Verification
REQ-031 Release reset, ready=1, 1-cycle memory returning 32'h0000_0013 -> first request addr 32'h8000_0000, inst_valid with inst_pc 32'h8000_0000 two cycles after request accept, next request 32'h8000_0004.
REQ-032 Request outstanding, pc_sel=1 br_target=32'h8000_0100 before response -> response discarded, inst_valid stays 0, next request addr 32'h8000_0100.
REQ-033 Buffer full, stall=1 for 5 cycles -> inst_valid and inst_pc stable, imem_req_valid=0; stall=0 -> consumed, request issued next cycle.
REQ-034 fence_i with fence_pc=32'h8000_0040 while WAIT -> response discarded, icache_flush high exactly 4 cycles, then request addr 32'h8000_0040.
REQ-035 Same cycle fence_i and pc_sel=3 exc_target=32'h0000_0100 -> no icache_flush, next request addr 32'h0000_0100.
REQ-036 pc = 32'hFFFF_FFFC accepted -> next request addr 32'h0000_0000; reset asserted during WAIT -> outputs at reset values asynchronously.
